// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings, state enum and control bundle for the multicycle MIPS controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

  localparam logic [1:0] ALU_SRC_B_REG    = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'd2;
  localparam logic [1:0] ALU_SRC_B_BRANCH = 2'd3;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Decode-state dispatch: anything not listed falls into the sticky trap.
  function automatic state_t decode_dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_RTYPE:     return S_EXEC_R;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
      OP_JAL:       return S_JAL;
      OP_ADDI:      return S_ADDI_EX;
      default:      return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational map from controller state to datapath control signals
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        // IR and PC only commit on the cycle the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_SRC_B_BRANCH;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MEM_TO_REG_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
      end
      // Link and jump share one cycle: the PC already holds the return address
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = MEM_TO_REG_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM: state register, sequencing and control outputs
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              mem_to_reg,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic [1:0]              pc_source,
  output logic                    illegal_op,
  output logic [3:0]              state_dbg
);

  state_t state;
  ctrl_t  ctrl;

  // funct is resolved by the ALU control and zero by the PC-write gate, both in the datapath
  logic unused_inputs;
  assign unused_inputs = ^{funct, zero};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (run) state <= S_FETCH;
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_dispatch(opcode);
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   if (mem_ready) state <= S_FETCH;
        S_EXEC_R:   state <= S_R_WB;
        S_R_WB:     state <= S_FETCH;
        S_ADDI_EX:  state <= S_ADDI_WB;
        S_ADDI_WB:  state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_JAL:      state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_IDLE;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for the multicycle MIPS controller
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       reg_write, alu_src_a, illegal_op;
  logic [3:0] state_dbg;
  logic [18:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  // Field order: pw pwc iod mr mw irw reg_dst mem_to_reg rw asa alu_src_b alu_op pc_source ill
  localparam logic [18:0] E_ZERO   = 19'd0;
  localparam logic [18:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,2'd0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd1,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd3,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd2,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_MWR    = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,2'd2,2'd0,1'b0};
  localparam logic [18:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,2'd0,2'd0,2'd0,1'b0};
  localparam logic [18:0] E_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,2'd0,2'd1,2'd1,1'b0};
  localparam logic [18:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,2'd0,2'd2,1'b0};
  localparam logic [18:0] E_JAL    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd2,2'd2,1'b1,1'b0,2'd0,2'd0,2'd2,1'b0};
  localparam logic [18:0] E_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,2'd0,2'd0,2'd0,1'b1};

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++;
    if (state_dbg !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state_dbg); end
    n_checks++;
    if (obs !== E_ZERO) begin n_fail++; $display("FAIL reset_outputs: got %h, required %h", obs, E_ZERO); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (state_dbg !== 4'd0 || obs !== E_ZERO) begin
      n_fail++; $display("FAIL idle_after_reset: state %0d outputs %h, required 0 and %h", state_dbg, obs, E_ZERO);
    end
  endtask

  task automatic test_rtype();
    state_t      st [5] = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB};
    logic [18:0] ev [5] = '{E_ZERO, E_FETCH, E_DECODE, E_EXR, E_RWB};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE; funct = 6'h20;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL rtype_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL rtype_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
    run = 1'b0;
  endtask

  task automatic test_lw_wait();
    state_t      st [7] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};
    logic [18:0] ev [7] = '{E_FETCH, E_DECODE, E_MADDR, E_MRD, E_MRD, E_MRD, E_MWB};
    logic        rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_ready = rdy[i]; opcode = OP_LW;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL lw_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL lw_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
  endtask

  task automatic test_jal();
    state_t      st [3] = '{S_FETCH, S_DECODE, S_JAL};
    logic [18:0] ev [3] = '{E_FETCH, E_DECODE, E_JAL};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1; opcode = OP_JAL;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL jal_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL jal_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
  endtask

  task automatic test_beq();
    state_t      st [7] = '{S_FETCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH};
    logic [18:0] ev [7] = '{E_FWAIT, E_FETCH, E_DECODE, E_BR, E_FETCH, E_DECODE, E_BR};
    logic        rdy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        zf [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_ready = rdy[i]; zero = zf[i]; opcode = OP_BEQ;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL beq_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL beq_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
  endtask

  task automatic test_back_to_back();
    state_t      st [11] = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR,
                             S_FETCH, S_DECODE, S_ADDI_EX, S_ADDI_WB,
                             S_FETCH, S_DECODE, S_JUMP};
    logic [18:0] ev [11] = '{E_FETCH, E_DECODE, E_MADDR, E_MWR,
                             E_FETCH, E_DECODE, E_MADDR, E_AWB,
                             E_FETCH, E_DECODE, E_JUMP};
    logic [5:0]  op [11] = '{OP_SW, OP_SW, OP_SW, OP_SW,
                             OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                             OP_J, OP_J, OP_J};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mem_ready = 1'b1; opcode = op[i];
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL b2b_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL b2b_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
  endtask

  task automatic test_trap();
    state_t      st [5] = '{S_FETCH, S_DECODE, S_TRAP, S_TRAP, S_TRAP};
    logic [18:0] ev [5] = '{E_FETCH, E_DECODE, E_TRAP, E_TRAP, E_TRAP};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'b1; opcode = 6'h3F; run = (i >= 2) ? i[0] : 1'b0;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL trap_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL trap_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
    run = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== 4'd0 || obs !== E_ZERO) begin
      n_fail++; $display("FAIL trap_reset: state %0d outputs %h, required 0 and %h", state_dbg, obs, E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (state_dbg !== 4'd0 || obs !== E_ZERO) begin
      n_fail++; $display("FAIL trap_cleared: state %0d outputs %h, required 0 and %h", state_dbg, obs, E_ZERO);
    end
  endtask

  task automatic test_reset_mid_wr();
    state_t      st [6] = '{S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR};
    logic [18:0] ev [6] = '{E_ZERO, E_FETCH, E_DECODE, E_MADDR, E_MWR, E_MWR};
    logic        rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run = 1'b1; mem_ready = rdy[i]; opcode = OP_SW;
      #1;
      n_checks++;
      if (state_dbg !== st[i]) begin n_fail++; $display("FAIL midwr_state step %0d: got %0d, required %0d", i, state_dbg, st[i]); end
      n_checks++;
      if (obs !== ev[i]) begin n_fail++; $display("FAIL midwr_outputs step %0d: got %h, required %h", i, obs, ev[i]); end
    end
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== 4'd0 || obs !== E_ZERO) begin
      n_fail++; $display("FAIL midwr_async_reset: state %0d outputs %h, required 0 and %h", state_dbg, obs, E_ZERO);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n = 1'b1; mem_ready = 1'b1;
      #1;
      n_checks++;
      if (state_dbg !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
        n_fail++; $display("FAIL midwr_after_reset cycle %0d: state %0d mem_write %b reg_write %b, required 0 0 0", i, state_dbg, mem_write, reg_write);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_jal();
    test_beq();
    test_back_to_back();
    test_trap();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
